ysyx_22050058_wb_arbiter: RTL and testbench

Write-side master for the integer register file. It arbitrates writeback results from the ALU (single-cycle) and LSU (multi-cycle loads) onto the register file's single write port, with 1-cycle registered latency. It keeps a per-register pending scoreboard so decode can stall on in-flight destinations and block WAW issue. It sits between the EXU/LSU and the register file write port; its busy outputs feed decode.

---
 rtl/ysyx_22050058_wb_arbiter_if.sv | 52 +++++
 rtl/ysyx_22050058_wb_arbiter.sv | 98 +++++++++
 tb/tb_ysyx_22050058_wb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050058_wb_arbiter_if.sv
// Writeback arbiter bus bundle: decode issue/check, ALU and LSU result
// handshakes, and the register file write port.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface ysyx_22050058_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  // Decode issue and source-operand check
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic              busy1_o;
  logic              busy2_o;

  // ALU result source
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  // LSU load result source
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;

  // Register file write port and sticky error
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              err_o;

  modport slave (
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output issue_ready, busy1_o, busy2_o,
    output alu_ready, lsu_ready,
    output we_o, waddr_o, wdata_o, err_o
  );

  modport master (
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, busy1_o, busy2_o,
    input  alu_ready, lsu_ready,
    input  we_o, waddr_o, wdata_o, err_o
  );
endinterface

// File: rtl/ysyx_22050058_wb_arbiter.sv
// Integer register file write-side master. Round-robin arbitration between
// ALU and LSU results onto the single write port (one cycle registered),
// plus a per-register pending scoreboard that drives decode stalls and
// blocks WAW issue.
module ysyx_22050058_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050058_wb_arbiter_if.slave   bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // x0 is hardwired, so its pending bit is masked off every cycle.
  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  src_e              last_grant;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  logic              alu_grant;
  logic              lsu_grant;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_rd;
  logic [DATA_W-1:0] xfer_data;
  logic              issue_ok;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  // Grant: a lone valid source wins; on a tie the source not granted last wins.
  always_comb begin
    alu_grant = bus.alu_valid & (~bus.lsu_valid | (last_grant == SRC_LSU));
    lsu_grant = bus.lsu_valid & ~alu_grant;
    xfer      = alu_grant | lsu_grant;
    xfer_rd   = alu_grant ? bus.alu_rd   : bus.lsu_rd;
    xfer_data = alu_grant ? bus.alu_data : bus.lsu_data;
  end

  // Scoreboard update: a writeback clears its rd, an accepted issue sets its rd.
  always_comb begin
    // NOTE: every variable gets a default before the conditionals so no
    // path leaves it unassigned, which would otherwise infer a latch.
    set_mask = '0;
    clr_mask = '0;
    issue_ok = (bus.issue_rd == '0) | ~pending[bus.issue_rd];
    if (bus.issue_valid && issue_ok) set_mask[bus.issue_rd] = 1'b1;
    if (xfer)                        clr_mask[xfer_rd]      = 1'b1;
    pending_next = ((pending & ~clr_mask) | set_mask) & X0_MASK;
  end

  // Registered write port, arbitration history, scoreboard and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, and must come out of
      // reset all-clear so decode never stalls on stale in-flight writes.
      pending    <= '0;
      last_grant <= SRC_LSU;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // e.g. err_q reads the old pending bit that is being cleared this edge.
      pending <= pending_next;
      we_q    <= xfer & (xfer_rd != '0);
      if (xfer) last_grant <= alu_grant ? SRC_ALU : SRC_LSU;
      // Writes to x0 are consumed silently; address/data keep their last values.
      if (xfer && (xfer_rd != '0)) begin
        waddr_q <= xfer_rd;
        wdata_q <= xfer_data;
        if (!pending[xfer_rd]) err_q <= 1'b1;
      end
    end
  end

  assign bus.issue_ready = issue_ok;
  assign bus.busy1_o     = pending[bus.chk_rs1];
  assign bus.busy2_o     = pending[bus.chk_rs2];
  assign bus.alu_ready   = alu_grant;
  assign bus.lsu_ready   = lsu_grant;
  assign bus.we_o        = we_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.wdata_o     = wdata_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_ysyx_22050058_wb_arbiter.sv
// Self-checking bench for ysyx_22050058_wb_arbiter: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic compared against
// a behavioural model of the grant, writeback and scoreboard rules.
module tb_ysyx_22050058_wb_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050058_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ysyx_22050058_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend[32];
  bit          m_last_alu;   // last transfer came from the ALU
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  bit          m_err;
  bit          e_ir, e_ar, e_lr;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last_alu = 1'b0;
    m_we       = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
    m_err      = 1'b0;
  endtask

  task automatic check_vs_model();
    e_ir = (bus.issue_rd == 5'd0) || !m_pend[bus.issue_rd];
    if (bus.alu_valid && bus.lsu_valid) begin
      e_ar = !m_last_alu;
      e_lr = m_last_alu;
    end else begin
      e_ar = bus.alu_valid;
      e_lr = bus.lsu_valid;
    end
    check("m_issue_ready", 64'(bus.issue_ready), 64'(e_ir));
    check("m_alu_ready",   64'(bus.alu_ready),   64'(e_ar));
    check("m_lsu_ready",   64'(bus.lsu_ready),   64'(e_lr));
    check("m_busy1",       64'(bus.busy1_o),     64'(m_pend[bus.chk_rs1]));
    check("m_busy2",       64'(bus.busy2_o),     64'(m_pend[bus.chk_rs2]));
    check("m_we",          64'(bus.we_o),        64'(m_we));
    check("m_waddr",       64'(bus.waddr_o),     64'(m_waddr));
    check("m_wdata",       bus.wdata_o,          m_wdata);
    check("m_err",         64'(bus.err_o),       64'(m_err));
  endtask

  task automatic model_edge();
    logic [4:0]  rd;
    logic [63:0] d;
    m_we = 1'b0;
    if (e_ar || e_lr) begin
      rd = e_ar ? bus.alu_rd : bus.lsu_rd;
      d  = e_ar ? bus.alu_data : bus.lsu_data;
      m_last_alu = e_ar;
      if (rd != 5'd0) begin
        if (!m_pend[rd]) m_err = 1'b1;
        m_pend[rd] = 1'b0;
        m_we    = 1'b1;
        m_waddr = rd;
        m_wdata = d;
      end
    end
    if (bus.issue_valid && e_ir && bus.issue_rd != 5'd0) m_pend[bus.issue_rd] = 1'b1;
  endtask

  // Called at a negedge with inputs applied; ends at the next negedge.
  task automatic cycle();
    #1;
    check_vs_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.chk_rs1 = '0;       bus.chk_rs2 = '0;
    bus.alu_valid = 1'b0;   bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0;   bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_before;
    bit          iv;  logic [4:0] ird;
    bit          av;  logic [4:0] ard; logic [63:0] ad;
    bit          lv;  logic [4:0] lrd; logic [63:0] ld;
    logic [4:0]  c1;  logic [4:0] c2;
    bit          e_ir, e_ar, e_lr, e_b1, e_b2, e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    bit          e_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [4:0] alu_q[$];
    logic [4:0] lsu_q[$];
    int ai, li;

    vecs[0] = '{1'b0, 1'b1,5'd5, 1'b0,5'd0,64'h0, 1'b0,5'd0,64'h0, 5'd5,5'd0,
                1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 64'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b0,5'd0, 1'b1,5'd5,64'hDEAD_BEEF, 1'b0,5'd0,64'h0, 5'd5,5'd0,
                1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 5'd0, 64'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b0,5'd0, 1'b0,5'd0,64'h0, 1'b0,5'd0,64'h0, 5'd5,5'd0,
                1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1,5'd3, 1'b0,5'd0,64'h0, 1'b0,5'd0,64'h0, 5'd3,5'd0,
                1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 64'h0, 1'b0};
    vecs[4] = '{1'b0, 1'b1,5'd7, 1'b0,5'd0,64'h0, 1'b0,5'd0,64'h0, 5'd3,5'd7,
                1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0, 64'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b0,5'd0, 1'b1,5'd3,64'h11, 1'b1,5'd7,64'h22, 5'd3,5'd7,
                1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 5'd0, 64'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b0,5'd0, 1'b0,5'd0,64'h0, 1'b1,5'd7,64'h22, 5'd3,5'd7,
                1'b1,1'b0,1'b1,1'b0,1'b1,1'b1, 5'd3, 64'h11, 1'b0};
    vecs[7] = '{1'b0, 1'b0,5'd0, 1'b0,5'd0,64'h0, 1'b0,5'd0,64'h0, 5'd3,5'd7,
                1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 5'd7, 64'h22, 1'b0};

    // Reset state
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_we",    64'(bus.we_o),    64'd0);
    check("rst_waddr", 64'(bus.waddr_o), 64'd0);
    check("rst_wdata", bus.wdata_o,      64'd0);
    check("rst_err",   64'(bus.err_o),   64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table: single writeback latency, then ALU/LSU tie after reset
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst_before) do_reset();
      bus.issue_valid = vecs[i].iv; bus.issue_rd = vecs[i].ird;
      bus.alu_valid = vecs[i].av;   bus.alu_rd = vecs[i].ard; bus.alu_data = vecs[i].ad;
      bus.lsu_valid = vecs[i].lv;   bus.lsu_rd = vecs[i].lrd; bus.lsu_data = vecs[i].ld;
      bus.chk_rs1 = vecs[i].c1;     bus.chk_rs2 = vecs[i].c2;
      #1;
      check($sformatf("v%0d_issue_ready", i), 64'(bus.issue_ready), 64'(vecs[i].e_ir));
      check($sformatf("v%0d_alu_ready", i),   64'(bus.alu_ready),   64'(vecs[i].e_ar));
      check($sformatf("v%0d_lsu_ready", i),   64'(bus.lsu_ready),   64'(vecs[i].e_lr));
      check($sformatf("v%0d_busy1", i),       64'(bus.busy1_o),     64'(vecs[i].e_b1));
      check($sformatf("v%0d_busy2", i),       64'(bus.busy2_o),     64'(vecs[i].e_b2));
      check($sformatf("v%0d_we", i),          64'(bus.we_o),        64'(vecs[i].e_we));
      check($sformatf("v%0d_waddr", i),       64'(bus.waddr_o),     64'(vecs[i].e_wa));
      check($sformatf("v%0d_wdata", i),       bus.wdata_o,          vecs[i].e_wd);
      check($sformatf("v%0d_err", i),         64'(bus.err_o),       64'(vecs[i].e_err));
      cycle();
    end

    // Continuous both-valid traffic: grants alternate, write port busy every cycle
    do_reset();
    for (int r = 1; r <= 6; r++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(r);
      cycle();
    end
    drive_idle();
    alu_q = '{5'd1, 5'd3, 5'd5};
    lsu_q = '{5'd2, 5'd4, 5'd6};
    ai = 0; li = 0;
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = (ai < 3); bus.alu_rd = (ai < 3) ? alu_q[ai] : 5'd0;
      bus.alu_data  = 64'h100 + 64'(bus.alu_rd);
      bus.lsu_valid = (li < 3); bus.lsu_rd = (li < 3) ? lsu_q[li] : 5'd0;
      bus.lsu_data  = 64'h200 + 64'(bus.lsu_rd);
      #1;
      check($sformatf("alt%0d_alu_ready", i), 64'(bus.alu_ready), 64'((i % 2) == 0));
      check($sformatf("alt%0d_overlap", i), 64'(bus.alu_ready & bus.lsu_ready), 64'd0);
      if (i > 0) check($sformatf("alt%0d_we", i), 64'(bus.we_o), 64'd1);
      if (bus.alu_ready) ai++;
      if (bus.lsu_ready) li++;
      cycle();
    end
    drive_idle();
    #1;
    check("alt_last_we",    64'(bus.we_o),    64'd1);
    check("alt_last_waddr", 64'(bus.waddr_o), 64'd6);
    cycle();

    // WAW block: re-issue of a pending rd waits for its writeback edge
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("waw_blocked", 64'(bus.issue_ready), 64'd0);
      cycle();
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 64'h99;
    #1;
    check("waw_blocked_at_wb", 64'(bus.issue_ready), 64'd0);
    check("waw_wb_ready",      64'(bus.alu_ready),   64'd1);
    cycle();
    bus.alu_valid = 1'b0;
    #1;
    check("waw_released", 64'(bus.issue_ready), 64'd1);
    cycle();
    bus.issue_rd = 5'd0; bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd9;
    #1;
    check("x0_issue_ready", 64'(bus.issue_ready), 64'd1);
    check("x0_busy",        64'(bus.busy1_o),     64'd0);
    check("reissued_busy",  64'(bus.busy2_o),     64'd1);
    cycle();

    // Writeback to x0: consumed, no write, no error
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'hFF;
    #1;
    check("x0_wb_ready", 64'(bus.alu_ready), 64'd1);
    cycle();
    drive_idle();
    #1;
    check("x0_wb_we",  64'(bus.we_o),  64'd0);
    check("x0_wb_err", 64'(bus.err_o), 64'd0);
    cycle();

    // Writeback to a never-issued register: write happens, error is sticky
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 64'h1212;
    cycle();
    drive_idle();
    #1;
    check("err_we",    64'(bus.we_o),    64'd1);
    check("err_waddr", 64'(bus.waddr_o), 64'd12);
    check("err_set",   64'(bus.err_o),   64'd1);
    repeat (3) cycle();
    #1;
    check("err_sticky", 64'(bus.err_o), 64'd1);

    // Reset mid-operation: set and clear of different regs, then async reset
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    cycle();
    bus.issue_rd = 5'd8;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 64'h44;
    cycle();
    bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    bus.chk_rs1 = 5'd9; bus.chk_rs2 = 5'd8;
    #1;
    check("pre_rst_we",    64'(bus.we_o),    64'd1);
    check("pre_rst_busy2", 64'(bus.busy2_o), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_we",    64'(bus.we_o),    64'd0);
    check("mid_rst_busy1", 64'(bus.busy1_o), 64'd0);
    check("mid_rst_busy2", 64'(bus.busy2_o), 64'd0);
    check("mid_rst_err",   64'(bus.err_o),   64'd0);
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
    cycle();
    bus.issue_rd = 5'd11;
    cycle();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 64'hA;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 64'hB;
    #1;
    check("post_rst_alu_first", 64'(bus.alu_ready), 64'd1);
    check("post_rst_lsu_wait",  64'(bus.lsu_ready), 64'd0);
    cycle();
    bus.alu_valid = 1'b0;
    cycle();
    drive_idle();
    cycle();

    // Randomized traffic against the model, sources hold until accepted
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 0) do_reset();
      if (!(bus.alu_valid && !e_ar)) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 5'($urandom_range(0, 15));
        bus.alu_data  = {$urandom, $urandom};
      end
      if (!(bus.lsu_valid && !e_lr)) begin
        bus.lsu_valid = 1'($urandom_range(0, 1));
        bus.lsu_rd    = 5'($urandom_range(0, 15));
        bus.lsu_data  = {$urandom, $urandom};
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 15));
      bus.chk_rs1     = 5'($urandom_range(0, 15));
      bus.chk_rs2     = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
